muldiv_sequencer: RTL and testbench

- Iterative 16-bit multiply/divide unit that owns and sequences the Hi/Lo special registers and the status divide-by-zero flag.
- Accepts a single operation from the decode/execute stage and runs a 16-step shift-add multiply or restoring divide.
- Drives the Hi/Lo/SR mirror inputs of the register file and stalls the pipeline while busy.

---
 rtl/muldiv_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Iterative 16-step shift-add multiply / restoring divide that owns Hi/Lo and the sticky dz flag.
// Latency: 17 edges from start to result (1 edge for divide by zero); start is ignored while busy.
module muldiv_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);
  localparam int AW = 2 * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [1:0]       op_q, op_d;
  logic             neg_res_q, neg_res_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dzop_q, dzop_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dz_q, dz_d;
  logic             done_q, done_d;

  logic             start_go;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [AW-1:0]    mul_step;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [AW-1:0]    div_step;
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dzop_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dzop_q    <= dzop_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
    end
  end

  assign start_go = (state_q == S_IDLE) && start && !flush;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          state_d = (op[1] && (b == '0)) ? S_FINISH : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Signed operands become magnitudes; 0x8000 maps onto itself, read as 32768.
  assign a_neg = op[0] & a[WIDTH-1];
  assign b_neg = op[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
  assign mul_sum  = {1'b0, acc_q[AW-1:WIDTH]} + {1'b0, opnd_q};
  assign mul_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[AW-1:1]};

  // Divide: acc = {partial remainder, dividend/quotient}; quotient bits enter at the LSB.
  assign div_shift = {acc_q[AW-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

  assign prod = neg_res_q ? -acc_q : acc_q;
  assign quot = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = neg_rem_q ? -acc_q[AW-1:WIDTH] : acc_q[AW-1:WIDTH];

  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dzop_d    = dzop_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dz_d      = dz_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_go) begin
          op_d      = op;
          cnt_d     = CW'(WIDTH - 1);
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          if (op[1] && (b == '0)) begin
            dzop_d = 1'b1;
            acc_d  = {a, {WIDTH{1'b1}}};
          end else if (op[1]) begin
            dzop_d = 1'b0;
            acc_d  = {{WIDTH{1'b0}}, a_mag};
            opnd_d = b_mag;
          end else begin
            dzop_d = 1'b0;
            acc_d  = {{WIDTH{1'b0}}, b_mag};
            opnd_d = a_mag;
          end
        end else if (!start) begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      S_CALC: begin
        if (!flush) begin
          acc_d = op_q[1] ? div_step : mul_step;
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FINISH: begin
        if (!flush) begin
          done_d = 1'b1;
          if (dzop_q) begin
            hi_d = acc_q[AW-1:WIDTH];
            lo_d = acc_q[WIDTH-1:0];
            dz_d = 1'b1;
          end else if (op_q[1]) begin
            hi_d = rem;
            lo_d = quot;
            dz_d = 1'b0;
          end else begin
            hi_d = prod[AW-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE);
    done = done_q;
    hi   = hi_q;
    lo   = lo_q;
    dz   = dz_q;
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Random and directed multiply/divide checks against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic [15:0] hi;
  logic [15:0] lo;
  logic        dz;

  int n_chk;
  int n_err;

  logic [15:0] m_hi;
  logic [15:0] m_lo;
  logic        m_dz;

  muldiv_sequencer #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dz    (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    longint      sp;
    int          sx, sy, q, r;
    case (o)
      2'b00: begin
        p = 32'(x) * 32'(y);
        m_hi = p[31:16];
        m_lo = p[15:0];
      end
      2'b01: begin
        sx = $signed(x);
        sy = $signed(y);
        sp = longint'(sx) * longint'(sy);
        p  = sp[31:0];
        m_hi = p[31:16];
        m_lo = p[15:0];
      end
      default: begin
        if (y == 16'd0) begin
          m_hi = x;
          m_lo = 16'hFFFF;
          m_dz = 1'b1;
        end else if (o == 2'b10) begin
          m_lo = x / y;
          m_hi = x % y;
          m_dz = 1'b0;
        end else begin
          sx = $signed(x);
          sy = $signed(y);
          q  = sx / sy;
          r  = sx % sy;
          m_lo = q[15:0];
          m_hi = r[15:0];
          m_dz = 1'b0;
        end
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    int   lat;
    int   exp_lat;
    logic ovl;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom(); b = $urandom();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    exp_lat = (o[1] && y == 16'd0) ? 1 : 17;
    lat = 0;
    ovl = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      ovl |= busy & done;
    end
    model(o, x, y);
    chk("latency", lat, exp_lat);
    chk("busy_done_overlap", {31'd0, ovl}, 32'd0);
    chk("hi", {16'd0, hi}, {16'd0, m_hi});
    chk("lo", {16'd0, lo}, {16'd0, m_lo});
    chk("dz", {31'd0, dz}, {31'd0, m_dz});
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'hFFFF;
      2: return 16'h0001;
      default: return 16'($urandom());
    endcase
  endfunction

  initial begin
    int   lat;
    logic seen;
    logic [15:0] x, y;
    logic [1:0]  o;
    n_chk = 0; n_err = 0;
    rst = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    #22;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hilo", {hi, lo}, 32'd0);
    chk("rst_dz", {31'd0, dz}, 32'd0);
    @(negedge clk); rst = 1'b1;

    do_op(2'b00, 16'hFFFF, 16'hFFFF);
    do_op(2'b01, 16'hFFFE, 16'h0003);
    do_op(2'b01, 16'h8000, 16'h8000);
    do_op(2'b11, 16'hFFF9, 16'h0002);
    do_op(2'b10, 16'd100,  16'd7);
    do_op(2'b10, 16'h0064, 16'h0000);
    do_op(2'b00, 16'h0003, 16'h0004);
    do_op(2'b10, 16'd10,   16'd3);
    do_op(2'b11, 16'h8000, 16'hFFFF);
    do_op(2'b11, 16'h8123, 16'h0000);

    // Move-to writes, then a start-while-busy and a flush mid-operation.
    @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wdata = 16'h1234;
    @(posedge clk); #1; hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 16'h1234; m_lo = 16'h1234;
    chk("mthi", {16'd0, hi}, 32'h1234);
    chk("mtlo", {16'd0, lo}, 32'h1234);
    @(negedge clk); start = 1'b1; op = 2'b00; a = 16'd2; b = 16'd3;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; op = 2'b10; a = 16'd9; b = 16'd0;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    chk("flush_hi", {16'd0, hi}, 32'h1234);
    chk("flush_dz", {31'd0, dz}, {31'd0, m_dz});

    // Move-to together with start: start wins.
    @(negedge clk); start = 1'b1; hi_we = 1'b1; wdata = 16'hAAAA; op = 2'b00; a = 16'd0; b = 16'd0;
    @(posedge clk); #1; start = 1'b0; hi_we = 1'b0;
    chk("mt_with_start", {16'd0, hi}, 32'h1234);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    chk("mt_start_lat", lat, 17);
    chk("mt_start_hi", {16'd0, hi}, 32'd0);
    m_hi = 16'd0; m_lo = 16'd0;

    // Asynchronous reset mid-operation.
    do_op(2'b10, 16'd5, 16'd0);
    @(negedge clk); start = 1'b1; op = 2'b00; a = 16'd7; b = 16'd9;
    @(posedge clk); #1; start = 1'b0;
    repeat (8) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hilo", {hi, lo}, 32'd0);
    chk("arst_dz", {31'd0, dz}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(negedge clk); rst = 1'b1;
    do_op(2'b00, 16'd5, 16'd5);

    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      x = pick();
      y = ($urandom_range(0, 7) == 0) ? 16'd0 : pick();
      do_op(o, x, y);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
